// File: rtl/fp16_cmp_minmax_if.sv
// Operand/result bus for the fp16 compare and min/max unit.
// A beat moves on a side only in a cycle where its valid and ready are both high; a valid
// beat holds its payload until it is taken, and ready may depend on state and downstream
// ready but never on the same side's valid.
interface fp16_cmp_minmax_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        invalid;

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, invalid
    );

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, invalid
    );
endinterface

// File: rtl/fp16_cmp_minmax.sv
// Two-stage binary16 FEQ/FLT/FLE/FMIN/FMAX unit (RISC-V Zfh semantics) with a
// valid/ready pipeline, plus the fp_class operand classifier it relies on.
module fp_class (
    input  logic [15:0] x,
    output logic        is_qnan,
    output logic        is_snan,
    output logic        is_zero
);
    logic exp_ones;
    logic mant_nz;

    assign exp_ones = &x[14:10];
    assign mant_nz  = |x[9:0];
    assign is_qnan  = exp_ones & x[9];
    assign is_snan  = exp_ones & ~x[9] & mant_nz;
    assign is_zero  = ~|x[14:0];
endmodule

module fp16_cmp_minmax #(
    parameter logic [15:0] CANON_NAN = 16'h7E00
) (
    input logic               clk,
    input logic               rst,
    fp16_cmp_minmax_if.slave  io
);
    localparam logic [2:0] OP_FEQ  = 3'd0;
    localparam logic [2:0] OP_FLT  = 3'd1;
    localparam logic [2:0] OP_FLE  = 3'd2;
    localparam logic [2:0] OP_FMIN = 3'd3;
    localparam logic [2:0] OP_FMAX = 3'd4;

    logic qa_w, sa_w, za_w, qb_w, sb_w, zb_w;

    fp_class u_class_a (.x(io.a), .is_qnan(qa_w), .is_snan(sa_w), .is_zero(za_w));
    fp_class u_class_b (.x(io.b), .is_qnan(qb_w), .is_snan(sb_w), .is_zero(zb_w));

    // Stage 1 state
    logic        s1_valid;
    logic [15:0] s1_a, s1_b;
    logic [2:0]  s1_op;
    logic        s1_qa, s1_sa, s1_za, s1_qb, s1_sb, s1_zb;
    logic        s1_lt_mag, s1_eq_mag;

    // Stage 2 state, which is also the output beat
    logic        s2_valid;
    logic [15:0] s2_result;
    logic        s2_invalid;

    logic s2_adv, s1_adv;

    assign s2_adv      = ~s2_valid | io.out_ready;
    assign s1_adv      = ~s1_valid | s2_adv;
    assign io.in_ready = s1_adv;

    assign io.out_valid = s2_valid;
    assign io.result    = s2_result;
    assign io.invalid   = s2_invalid;

    logic a_nan, b_nan, any_nan, both_zero, eq, lt;
    logic [15:0] res_d;
    logic        inv_d;

    assign a_nan     = s1_qa | s1_sa;
    assign b_nan     = s1_qb | s1_sb;
    assign any_nan   = a_nan | b_nan;
    assign both_zero = s1_za & s1_zb;
    assign eq        = ~any_nan & (both_zero | (s1_a == s1_b));
    // Sign-magnitude ordering; for two negatives the larger magnitude is the smaller value.
    assign lt        = ~any_nan & ~both_zero &
                       ((s1_a[15] & ~s1_b[15]) |
                        (~s1_a[15] & ~s1_b[15] & s1_lt_mag) |
                        (s1_a[15] & s1_b[15] & ~s1_lt_mag & ~s1_eq_mag));

    always_comb begin
        res_d = 16'h0000;
        inv_d = 1'b0;
        case (s1_op)
            OP_FEQ: begin
                res_d = {15'b0, eq};
                inv_d = s1_sa | s1_sb;
            end
            OP_FLT: begin
                res_d = {15'b0, lt};
                inv_d = any_nan;
            end
            OP_FLE: begin
                res_d = {15'b0, lt | eq};
                inv_d = any_nan;
            end
            OP_FMIN, OP_FMAX: begin
                inv_d = s1_sa | s1_sb;
                if (a_nan & b_nan) begin
                    res_d = CANON_NAN;
                end else if (a_nan) begin
                    res_d = s1_b;
                end else if (b_nan) begin
                    res_d = s1_a;
                end else if (both_zero) begin
                    // -0 orders below +0 here, unlike in the compares.
                    if (s1_op == OP_FMIN) res_d = s1_a[15] ? s1_a : s1_b;
                    else                  res_d = s1_a[15] ? s1_b : s1_a;
                end else if (s1_op == OP_FMIN) begin
                    res_d = (lt | eq) ? s1_a : s1_b;
                end else begin
                    res_d = lt ? s1_b : s1_a;
                end
            end
            default: begin
                res_d = 16'h0000;
                inv_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_a       <= 16'h0000;
            s1_b       <= 16'h0000;
            s1_op      <= 3'd0;
            s1_qa      <= 1'b0;
            s1_sa      <= 1'b0;
            s1_za      <= 1'b0;
            s1_qb      <= 1'b0;
            s1_sb      <= 1'b0;
            s1_zb      <= 1'b0;
            s1_lt_mag  <= 1'b0;
            s1_eq_mag  <= 1'b0;
            s2_valid   <= 1'b0;
            s2_result  <= 16'h0000;
            s2_invalid <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_valid <= io.in_valid;
                if (io.in_valid) begin
                    s1_a      <= io.a;
                    s1_b      <= io.b;
                    s1_op     <= io.op;
                    s1_qa     <= qa_w;
                    s1_sa     <= sa_w;
                    s1_za     <= za_w;
                    s1_qb     <= qb_w;
                    s1_sb     <= sb_w;
                    s1_zb     <= zb_w;
                    s1_lt_mag <= io.a[14:0] < io.b[14:0];
                    s1_eq_mag <= io.a[14:0] == io.b[14:0];
                end
            end
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_result  <= res_d;
                    s2_invalid <= inv_d;
                end
            end
        end
    end
endmodule

// File: doc/fp16_cmp_minmax.md
Name: fp16_cmp_minmax

Overview:
- Two-stage pipelined IEEE-754 binary16 compare and min/max unit.
- Sits downstream of the fp_class classifier: it instantiates fp_class once per operand and uses only the qNaN, sNaN and zero outputs.
- Implements FEQ/FLT/FLE/FMIN/FMAX with RISC-V Zfh semantics.
- Valid/ready handshake on both sides, so it drops into the FPU issue/writeback path.

Parameters:
- CANON_NAN, 16'h7E00, canonical quiet NaN returned by FMIN/FMAX when both operands are NaN.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  unit accepts beat this cycle
- op  input  3  0=FEQ, 1=FLT, 2=FLE, 3=FMIN, 4=FMAX, 5-7 reserved
- a  input  16  operand A, binary16
- b  input  16  operand B, binary16
- out_valid  output  1  result beat valid
- out_ready  input  1  consumer accepts result
- result  output  16  compare: {15'b0, bit}; min/max: selected binary16 value
- invalid  output  1  IEEE invalid-operation flag for this result beat

Behaviour:
- Reset (async, rst=1): s1_valid=0, s2_valid=0, out_valid=0, result=16'h0000, invalid=0. Datapath registers are cleared to 0.
- Handshake and stall:
  - Accept occurs when in_valid & in_ready. Result transfers when out_valid & out_ready.
  - s2 advances when !s2_valid | out_ready.
  - s1 advances when !s1_valid | s2 advances.
  - in_ready = s1 advance condition (combinational from out_ready; no combinational path from in_valid).
  - While stalled, out_valid, result and invalid hold stable.
- Latency and throughput: a beat accepted at cycle N appears with out_valid=1 at N+2 if never stalled. Throughput is 1 beat/cycle. Order is preserved.
- Stage 1 registers a, b, op, per-operand {qNaN, sNaN, zero} from fp_class, and:
  - a_lt_mag: a[14:0] < b[14:0]
  - a_eq_mag: a[14:0] == b[14:0]
- Stage 2 computes ordering:
  - anyNaN = qa|sa|qb|sb.
  - both_zero: the two ±0 values compare equal.
  - eq = !anyNaN & (both_zero | a==b bitwise).
  - lt = !anyNaN & !both_zero & one of:
    - a neg, b pos
    - both pos & a_lt_mag
    - both neg & !a_lt_mag & !a_eq_mag
- Stage 2 result by op:
  - FEQ: bit0=eq. invalid = sa|sb.
  - FLT: bit0=lt. invalid = anyNaN.
  - FLE: bit0=lt|eq. invalid = anyNaN.
  - FMIN/FMAX:
    - Both NaN → CANON_NAN.
    - Exactly one NaN → the other operand.
    - Else the smaller (FMIN) or larger (FMAX) by lt.
    - -0 is treated as less than +0, so FMIN(+0,-0) = 16'h8000 and FMAX = 16'h0000.
    - Equal non-zero values return a.
    - invalid = sa|sb.
  - Reserved op: result=0, invalid=0, beat still flows through the pipeline.
- Boundary conditions:
  - Infinities order normally: -inf < all < +inf.
  - Subnormals order by magnitude.
  - A NaN input never produces a NaN payload at the output except CANON_NAN.
- Simultaneous accept and emit: when s2 drains while s1 fills, no bubble is inserted and no beat is lost.
- Reset mid-operation: all in-flight beats are discarded and out_valid drops immediately on assertion of rst.

Test Plan:
- FLT a=16'h3C00 (1.0), b=16'h4000 (2.0), out_ready=1 → result=16'h0001, invalid=0, out_valid at cycle N+2.
- FEQ a=16'h0000, b=16'h8000 → result=1, invalid=0. FEQ a=16'h7D00 (sNaN), b=16'h3C00 → result=0, invalid=1. FLE a=16'h7E00, b=16'h3C00 → result=0, invalid=1.
- FMIN a=16'h0000, b=16'h8000 → result=16'h8000. FMAX a=16'h7E00, b=16'hC000 → result=16'hC000, invalid=0. FMAX a=16'h7C01, b=16'h7E00 → result=16'h7E00, invalid=1.
- FLT a=16'hC000 (-2), b=16'hBC00 (-1) → 1. FLT a=16'hFC00 (-inf), b=16'h0001 (subnormal) → 1. FLT a=16'h0001, b=16'h0000 → 0.
- Back-to-back 8 beats with out_ready held 0 for 3 cycles mid-stream:
  - in_ready drops once both stages are full.
  - Outputs hold stable during the stall.
  - All 8 results arrive in order with no loss or duplication.
- Assert rst while 2 beats are in flight → out_valid=0, result=0, invalid=0 immediately. After release, the first new beat emerges 2 cycles after acceptance.
